floo_vc_input_port: RTL and testbench
=====================================

FLOO_VC_INPUT_PORT -- requirements
Module: floo_vc_input_port

Interface
REQ-001 SHALL have parameter NumVC, default 4, meaning the number of virtual channels buffered at this input port.
REQ-002 SHALL have parameter NumVCWidth, default 2, meaning the width of the VC id, with NumVCWidth >= $clog2(NumVC).
REQ-003 SHALL have parameter VCDepth, default 2, meaning the flit slots per VC; legal values are 1 and above.
REQ-004 SHALL have parameters flit_t (default logic), hdr_t (default logic) and flit_payload_t (default logic[$bits(flit_t)-$bits(hdr_t)-1:0]), meaning the flit, header and payload types.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port valid_i, input, 1 bit: an incoming flit is present this cycle.
REQ-008 SHALL have port data_i, input, flit_t: the incoming flit; the target VC is data_i.hdr.vc_id.
REQ-009 SHALL have port vc_valid_o, output, [NumVC-1:0]: the VC holds at least one flit.
REQ-010 SHALL have port vc_data_head_o, output, [NumVC-1:0] flit_payload_t: the head payload per VC.
REQ-011 SHALL have port vc_hdr_head_o, output, [NumVC-1:0] hdr_t: the head header per VC.
REQ-012 SHALL have port read_vc_id_oh_i, input, [NumVC-1:0]: a one-hot pop of the head of the selected VC; all-zero means no pop.
REQ-013 SHALL have port credit_v_o, output, 1 bit: a credit return to the upstream router is valid.
REQ-014 SHALL have port credit_id_o, output, [NumVCWidth-1:0]: the VC the returned credit belongs to.
REQ-015 SHALL have port err_o, output, 1 bit: a one-cycle pulse on protocol violation.

Function
REQ-016 SHALL write data_i into the FIFO of VC data_i.hdr.vc_id on a cycle with valid_i=1; payload and header are stored together.
REQ-017 SHALL present a written flit on the head outputs in the cycle after the write, with no combinational bypass; write-to-head latency is 1 cycle.
REQ-018 SHALL drive vc_valid_o[v] purely from registered occupancy: it is 1 exactly when count[v] > 0.
REQ-019 SHALL hold vc_data_head_o[v] and vc_hdr_head_o[v] stable while vc_valid_o[v]=1 and VC v is not popped; their value is don't-care when VC v is empty.
REQ-020 SHALL, on a pop of a non-empty VC v, advance v's read pointer and decrement count[v] in the same clock edge.
REQ-021 SHALL implement each VC as a circular buffer with pointers that wrap from VCDepth-1 to 0 and a count that ranges from 0 to VCDepth.
REQ-022 SHALL, on a simultaneous write and pop to the same VC, keep count unchanged and move both pointers; this holds even when the VC is full.
REQ-023 SHALL, on a write to a full VC with no same-cycle pop of that VC, drop the flit, leave state unchanged and pulse err_o the next cycle.
REQ-024 SHALL, on a write with vc_id >= NumVC, drop the flit and pulse err_o the next cycle.
REQ-025 SHALL, on a pop of an empty VC or a non-one-hot read_vc_id_oh_i, ignore the pop, return no credit and pulse err_o the next cycle.
REQ-026 SHALL, for each accepted pop of VC v, drive credit_v_o=1 with credit_id_o=v in the following cycle, from registered outputs; at most one credit is returned per cycle.
REQ-027 SHALL drive credit_id_o to 0 whenever credit_v_o=0.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, clear all pointers and counts, and drive vc_valid_o=0, credit_v_o=0, credit_id_o=0 and err_o=0 after that edge.
REQ-029 SHALL discard any write or pop presented in a reset cycle, and SHALL NOT emit a credit for a pop concurrent with reset.
REQ-030 SHALL leave stored flit data unreset; only control state is reset.

Structure
REQ-031 SHALL take flit_t and hdr_t from the shared package floo_pkg-based typedef macros; hdr_t contains vc_id, lookahead and last.
REQ-032 SHALL instantiate one sub-module, floo_vc_input_fifo, once per VC, holding the pointers, count and storage; credit and error logic stay in the top level.

Verification
REQ-033 SHALL cover: NumVC=4, VCDepth=2; write to VC2 at cycle 0 -> vc_valid_o=4'b0100 at cycle 1, payload matches.
REQ-034 SHALL cover: fill VC1 with A,B, then pop at cycles 3 and 4 -> heads A then B; credit_v_o=1 with id 1 at cycles 4 and 5; vc_valid_o[1]=0 at cycle 5.
REQ-035 SHALL cover: VC0 full, then write C with simultaneous pop of VC0 -> no err_o, count stays 2, C emerges after the old second flit.
REQ-036 SHALL cover: VC3 full, then a write with no pop -> err_o pulses once, the flit is dropped, and heads are unchanged.
REQ-037 SHALL cover: pop of an empty VC or read_vc_id_oh_i=4'b0011 -> err_o=1 next cycle, credit_v_o=0, state unchanged.
REQ-038 SHALL cover: rst_i asserted mid-stream with VCs non-empty -> all vc_valid_o=0 next cycle, no credit, and the FIFO works normally afterwards.

Source files
------------

// File: rtl/floo_vc_input_port_pkg.sv
// Shared types and helpers for the virtual-channel input port.
// The default flit is a header (vc_id, lookahead, last) followed by the payload.
package floo_vc_input_port_pkg;

  localparam int unsigned VcIdWidth    = 3;
  localparam int unsigned PayloadWidth = 16;

  typedef struct packed {
    logic [VcIdWidth-1:0] vc_id;
    logic                 lookahead;
    logic                 last;
  } floo_hdr_t;

  typedef logic [PayloadWidth-1:0] floo_payload_t;

  typedef struct packed {
    floo_hdr_t     hdr;
    floo_payload_t payload;
  } floo_flit_t;

  // Pointer width for a circular buffer; a single-slot buffer still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/floo_vc_input_fifo.sv
// Single virtual-channel circular buffer. The caller only asserts push_i / pop_i
// for legal operations; a push together with a pop is legal even when full.
module floo_vc_input_fifo
  import floo_vc_input_port_pkg::*;
#(
  parameter int unsigned Depth  = 2,
  parameter type         data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  data_t data_i,
  output logic  valid_o,
  output logic  full_o,
  output data_t head_o
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  data_t           r_mem [Depth];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  // Advance a pointer, wrapping from the last slot back to slot 0.
  function automatic logic [PtrW-1:0] adv(input logic [PtrW-1:0] p);
    if (p == LastPtr) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  // Pointer and occupancy state; simultaneous push and pop keeps the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= {PtrW{1'b0}};
      r_rptr  <= {PtrW{1'b0}};
      r_count <= {CntW{1'b0}};
    end else begin
      if (push_i) begin
        r_wptr <= adv(r_wptr);
      end
      if (pop_i) begin
        r_rptr <= adv(r_rptr);
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Flit storage; data is not reset, only the control state above is.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  assign valid_o = (r_count != {CntW{1'b0}});
  assign full_o  = (r_count == FullCnt);
  assign head_o  = r_mem[r_rptr];

endmodule

// File: rtl/floo_vc_input_port.sv
// Router input port with one FIFO per virtual channel. Pops return a credit to
// the upstream router one cycle later; protocol violations pulse err_o.
module floo_vc_input_port
  import floo_vc_input_port_pkg::*;
#(
  parameter int unsigned NumVC          = 4,
  parameter int unsigned NumVCWidth     = 2,
  parameter int unsigned VCDepth        = 2,
  parameter type         flit_t         = floo_flit_t,
  parameter type         hdr_t          = floo_hdr_t,
  parameter type         flit_payload_t = logic [$bits(flit_t)-$bits(hdr_t)-1:0]
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  flit_t                        data_i,
  output logic          [NumVC-1:0]    vc_valid_o,
  output flit_payload_t [NumVC-1:0]    vc_data_head_o,
  output hdr_t          [NumVC-1:0]    vc_hdr_head_o,
  input  logic          [NumVC-1:0]    read_vc_id_oh_i,
  output logic                         credit_v_o,
  output logic          [NumVCWidth-1:0] credit_id_o,
  output logic                         err_o
);

  localparam int unsigned PayW = $bits(flit_payload_t);

  logic [31:0]           w_vc_id;
  logic                  w_vc_in_range;
  logic [NumVC-1:0]      w_full;
  logic [NumVC-1:0]      w_vc_valid;
  logic [NumVC-1:0]      w_pop_en;
  logic [NumVC-1:0]      w_wr_en;
  logic                  w_pop_ok;
  logic                  w_pop_err;
  logic                  w_wr_drop_full;
  logic                  w_wr_err;
  logic [NumVCWidth-1:0] w_pop_id;
  flit_t                 w_head [NumVC];

  logic                  r_credit_v;
  logic [NumVCWidth-1:0] r_credit_id;
  logic                  r_err;

  assign w_vc_id       = 32'(data_i.hdr.vc_id);
  assign w_vc_in_range = (w_vc_id < NumVC);

  // Pop qualification: exactly one VC selected and that VC holds a flit.
  always_comb begin
    w_pop_ok  = $onehot(read_vc_id_oh_i) && (|(read_vc_id_oh_i & w_vc_valid));
    w_pop_err = (|read_vc_id_oh_i) && !w_pop_ok;
    if (w_pop_ok && !rst_i) begin
      w_pop_en = read_vc_id_oh_i;
    end else begin
      w_pop_en = {NumVC{1'b0}};
    end
  end

  // Binary id of the popped VC, used as the credit id.
  always_comb begin
    w_pop_id = {NumVCWidth{1'b0}};
    for (int v = 0; v < NumVC; v++) begin
      if (read_vc_id_oh_i[v]) begin
        w_pop_id = NumVCWidth'(v);
      end else begin
        w_pop_id = w_pop_id;
      end
    end
  end

  // Write steering: a full VC only accepts when it is popped in the same cycle.
  always_comb begin
    w_wr_en        = {NumVC{1'b0}};
    w_wr_drop_full = 1'b0;
    for (int v = 0; v < NumVC; v++) begin
      if (valid_i && w_vc_in_range && (w_vc_id == 32'(v))) begin
        if (!w_full[v] || w_pop_en[v]) begin
          w_wr_en[v] = !rst_i;
        end else begin
          w_wr_drop_full = 1'b1;
        end
      end else begin
        w_wr_en[v] = 1'b0;
      end
    end
    w_wr_err = valid_i && (!w_vc_in_range || w_wr_drop_full);
  end

  for (genvar g = 0; g < NumVC; g++) begin : gen_vc
    floo_vc_input_fifo #(
      .Depth  (VCDepth),
      .data_t (flit_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_wr_en[g]),
      .pop_i   (w_pop_en[g]),
      .data_i  (data_i),
      .valid_o (w_vc_valid[g]),
      .full_o  (w_full[g]),
      .head_o  (w_head[g])
    );

    assign vc_hdr_head_o[g]  = w_head[g].hdr;
    assign vc_data_head_o[g] = w_head[g][PayW-1:0];
  end

  // Registered credit return and error pulse, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_credit_v  <= 1'b0;
      r_credit_id <= {NumVCWidth{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_credit_v  <= |w_pop_en;
      r_credit_id <= (|w_pop_en) ? w_pop_id : {NumVCWidth{1'b0}};
      r_err       <= w_pop_err || w_wr_err;
    end
  end

  assign vc_valid_o  = w_vc_valid;
  assign credit_v_o  = r_credit_v;
  assign credit_id_o = r_credit_id;
  assign err_o       = r_err;

endmodule

// File: tb/tb_floo_vc_input_port.sv
// Directed bench for floo_vc_input_port with NumVC=4, VCDepth=2.
module tb_floo_vc_input_port;
  import floo_vc_input_port_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 valid;
  floo_flit_t           data;
  logic [3:0]           vc_valid;
  logic [3:0][15:0]     head_data;
  floo_hdr_t [3:0]      head_hdr;
  logic [3:0]           read_oh;
  logic                 credit_v;
  logic [1:0]           credit_id;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;

  floo_vc_input_port #(
    .NumVC      (4),
    .NumVCWidth (2),
    .VCDepth    (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .valid_i         (valid),
    .data_i          (data),
    .vc_valid_o      (vc_valid),
    .vc_data_head_o  (head_data),
    .vc_hdr_head_o   (head_hdr),
    .read_vc_id_oh_i (read_oh),
    .credit_v_o      (credit_v),
    .credit_id_o     (credit_id),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic floo_flit_t mk(input logic [2:0] vc, input logic [15:0] pay);
    floo_flit_t f;
    f.hdr.vc_id     = vc;
    f.hdr.lookahead = 1'b0;
    f.hdr.last      = 1'b1;
    f.payload       = pay;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; read_oh = 4'b0000; data = mk(3'd0, 16'h0000);
    tick(); tick();
    chk("rst_vc_valid", 32'(vc_valid), 32'h0);
    chk("rst_credit_v", 32'(credit_v), 32'h0);
    chk("rst_credit_id", 32'(credit_id), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Single write to VC2, visible one cycle later
    valid = 1'b1; data = mk(3'd2, 16'hA2A2);
    tick(); valid = 1'b0;
    chk("w2_vc_valid", 32'(vc_valid), 32'h4);
    chk("w2_payload", 32'(head_data[2]), 32'hA2A2);
    chk("w2_hdr_vc", 32'(head_hdr[2].vc_id), 32'h2);
    chk("w2_err", 32'(err), 32'h0);
    chk("w2_credit_v", 32'(credit_v), 32'h0);
    read_oh = 4'b0100;
    tick(); read_oh = 4'b0000;
    chk("p2_credit_v", 32'(credit_v), 32'h1);
    chk("p2_credit_id", 32'(credit_id), 32'h2);
    chk("p2_vc_valid", 32'(vc_valid), 32'h0);

    // Fill VC1 with A,B then pop twice
    valid = 1'b1; data = mk(3'd1, 16'hAAAA); tick();
    data = mk(3'd1, 16'hBBBB); tick(); valid = 1'b0;
    chk("f1_vc_valid", 32'(vc_valid), 32'h2);
    chk("f1_head_a", 32'(head_data[1]), 32'hAAAA);
    chk("f1_credit_id", 32'(credit_id), 32'h0);
    read_oh = 4'b0010; tick();
    chk("p1a_credit_v", 32'(credit_v), 32'h1);
    chk("p1a_credit_id", 32'(credit_id), 32'h1);
    chk("p1a_head_b", 32'(head_data[1]), 32'hBBBB);
    chk("p1a_vc_valid", 32'(vc_valid), 32'h2);
    tick(); read_oh = 4'b0000;
    chk("p1b_credit_v", 32'(credit_v), 32'h1);
    chk("p1b_credit_id", 32'(credit_id), 32'h1);
    chk("p1b_vc_valid", 32'(vc_valid), 32'h0);
    tick();
    chk("idle_credit_v", 32'(credit_v), 32'h0);
    chk("idle_credit_id", 32'(credit_id), 32'h0);

    // VC0 full, write C with simultaneous pop
    valid = 1'b1; data = mk(3'd0, 16'h0101); tick();
    data = mk(3'd0, 16'h0202); tick();
    data = mk(3'd0, 16'h0C0C); read_oh = 4'b0001; tick();
    chk("wp0_err", 32'(err), 32'h0);
    chk("wp0_head", 32'(head_data[0]), 32'h0202);
    chk("wp0_vc_valid", 32'(vc_valid), 32'h1);
    chk("wp0_credit_id", 32'(credit_id), 32'h0);
    chk("wp0_credit_v", 32'(credit_v), 32'h1);
    read_oh = 4'b0000; data = mk(3'd0, 16'h0D0D); tick(); valid = 1'b0;
    chk("full0_err", 32'(err), 32'h1);
    chk("full0_head", 32'(head_data[0]), 32'h0202);
    chk("full0_credit_v", 32'(credit_v), 32'h0);
    read_oh = 4'b0001; tick();
    chk("p0a_head_c", 32'(head_data[0]), 32'h0C0C);
    chk("p0a_err", 32'(err), 32'h0);
    tick(); read_oh = 4'b0000;
    chk("p0b_vc_valid", 32'(vc_valid), 32'h0);

    // VC3 full, write without pop is dropped
    valid = 1'b1; data = mk(3'd3, 16'h3111); tick();
    data = mk(3'd3, 16'h3222); tick();
    data = mk(3'd3, 16'h3333); tick(); valid = 1'b0;
    chk("full3_err", 32'(err), 32'h1);
    chk("full3_head", 32'(head_data[3]), 32'h3111);
    tick();
    chk("full3_err_once", 32'(err), 32'h0);
    chk("full3_head_hold", 32'(head_data[3]), 32'h3111);
    chk("full3_vc_valid", 32'(vc_valid), 32'h8);
    read_oh = 4'b1000; tick();
    chk("p3a_head", 32'(head_data[3]), 32'h3222);
    tick(); read_oh = 4'b0000;
    chk("p3b_vc_valid", 32'(vc_valid), 32'h0);
    chk("p3b_credit_id", 32'(credit_id), 32'h3);

    // Illegal pops: empty VC, then non-one-hot
    read_oh = 4'b0100; tick(); read_oh = 4'b0000;
    chk("pe_err", 32'(err), 32'h1);
    chk("pe_credit_v", 32'(credit_v), 32'h0);
    chk("pe_vc_valid", 32'(vc_valid), 32'h0);
    valid = 1'b1; data = mk(3'd0, 16'h0E0E); tick();
    data = mk(3'd1, 16'h1E1E); tick(); valid = 1'b0;
    read_oh = 4'b0011; tick(); read_oh = 4'b0000;
    chk("oh_err", 32'(err), 32'h1);
    chk("oh_credit_v", 32'(credit_v), 32'h0);
    chk("oh_vc_valid", 32'(vc_valid), 32'h3);
    chk("oh_head0", 32'(head_data[0]), 32'h0E0E);
    chk("oh_head1", 32'(head_data[1]), 32'h1E1E);

    // Out-of-range VC id
    valid = 1'b1; data = mk(3'd5, 16'h5A5A); tick(); valid = 1'b0;
    chk("oor_err", 32'(err), 32'h1);
    chk("oor_vc_valid", 32'(vc_valid), 32'h3);

    // Reset mid-stream with concurrent write and pop
    valid = 1'b1; data = mk(3'd2, 16'h2F2F); tick();
    rst = 1'b1; data = mk(3'd3, 16'h3F3F); read_oh = 4'b0001; tick();
    rst = 1'b0; valid = 1'b0; read_oh = 4'b0000;
    chk("mrst_vc_valid", 32'(vc_valid), 32'h0);
    chk("mrst_credit_v", 32'(credit_v), 32'h0);
    chk("mrst_credit_id", 32'(credit_id), 32'h0);
    chk("mrst_err", 32'(err), 32'h0);
    tick();
    chk("mrst_post_vc_valid", 32'(vc_valid), 32'h0);
    chk("mrst_post_credit_v", 32'(credit_v), 32'h0);
    valid = 1'b1; data = mk(3'd3, 16'h5555); tick(); valid = 1'b0;
    chk("arst_vc_valid", 32'(vc_valid), 32'h8);
    chk("arst_head", 32'(head_data[3]), 32'h5555);
    read_oh = 4'b1000; tick(); read_oh = 4'b0000;
    chk("arst_credit_v", 32'(credit_v), 32'h1);
    chk("arst_credit_id", 32'(credit_id), 32'h3);
    chk("arst_empty", 32'(vc_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
